irq_controller: RTL and testbench

Interrupt controller between external interrupt sources and the pipelined `Processor` core. It edge-detects up to `NUM_SRC` interrupt lines into a pending register and applies a software mask. It presents the highest-priority unmasked request to the core with a cause index and trap vector, and runs a request/acknowledge/return handshake. Only one interrupt is in service at a time.

---
 rtl/irq_controller_if.sv | 29 ++
 rtl/irq_controller.sv | 115 +++++++++++
 tb/tb_irq_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Interrupt controller bundle between interrupt sources/CSR writes and the core.
// master = controller side, slave = core/source side.
interface irq_controller_if #(
    parameter int unsigned NUM_SRC = 8
);
    localparam int unsigned CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] irq_in;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               irq_req;
    logic [CW-1:0]      irq_cause;
    logic [31:0]        irq_vector;
    logic               irq_ack;
    logic               irq_ret;
    logic               irq_active;
    logic [NUM_SRC-1:0] pending;
    logic [31:0]        irq_count;

    modport master (
        input  irq_in, mask_we, mask_wdata, irq_ack, irq_ret,
        output irq_req, irq_cause, irq_vector, irq_active, pending, irq_count
    );

    modport slave (
        output irq_in, mask_we, mask_wdata, irq_ack, irq_ret,
        input  irq_req, irq_cause, irq_vector, irq_active, pending, irq_count
    );
endinterface

// File: rtl/irq_controller.sv
// Edge-detecting, maskable, fixed-priority interrupt controller with a single-level
// req/ack/ret handshake. Define IRQ_COUNT_EN to enable the serviced-interrupt counter.
module irq_controller #(
    parameter int unsigned NUM_SRC  = 8,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input logic clk,
    input logic reset,
    irq_controller_if.master bus
);
    localparam int unsigned CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] irq_in_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic               req_q, req_d;
    logic               active_q, active_d;
    logic [CW-1:0]      cause_q, cause_d;
    logic [CW-1:0]      win_c;
    logic               ack_ok_c;
    logic [NUM_SRC-1:0] event_c;
    logic [NUM_SRC-1:0] eligible_c;
    logic [NUM_SRC-1:0] clr_c;

    assign event_c    = bus.irq_in & ~irq_in_q;
    assign eligible_c = pending_q & mask_q;
    assign clr_c      = ack_ok_c ? (NUM_SRC'(1) << cause_q) : '0;
    // Set beats clear when an event lands on the bit being acknowledged
    assign pending_d  = (pending_q & ~clr_c) | event_c;

    // Fixed priority: scan downward so the lowest eligible index is assigned last
    always_comb begin
        win_c = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible_c[i]) win_c = CW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        active_d = active_q;
        cause_d  = cause_q;
        ack_ok_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible_c) begin
                    cause_d = win_c;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    ack_ok_c = 1'b1;
                    req_d    = 1'b0;
                    active_d = 1'b1;
                    state_d  = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.irq_ret) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_in_q  <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            req_q     <= 1'b0;
            active_q  <= 1'b0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            irq_in_q  <= bus.irq_in;
            pending_q <= pending_d;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
            req_q     <= req_d;
            active_q  <= active_d;
            cause_q   <= cause_d;
        end
    end

`ifdef IRQ_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 32'h0;
        end else if (ack_ok_c) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.irq_count = count_q;
`else
    assign bus.irq_count = 32'h0;
`endif

    assign bus.irq_req    = req_q;
    assign bus.irq_active = active_q;
    assign bus.irq_cause  = cause_q;
    assign bus.pending    = pending_q;
    assign bus.irq_vector = VEC_BASE + (32'(cause_q) << 2);
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: vector table for the handshake flow plus
// hand-written sequences for async reset, counter and held-high lines.
module tb_irq_controller;
    localparam int unsigned NUM_SRC = 8;
`ifdef IRQ_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    irq_controller_if #(.NUM_SRC(NUM_SRC)) bus ();

    irq_controller #(.NUM_SRC(NUM_SRC), .VEC_BASE(32'h0000_0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq_in;
        logic       mask_we;
        logic [7:0] mask_wdata;
        logic       ack;
        logic       ret;
        logic       exp_req;
        logic [2:0] exp_cause;
        logic       exp_active;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] irq_in, logic mask_we, logic [7:0] mask_wdata,
                                logic ack, logic ret, logic exp_req, logic [2:0] exp_cause,
                                logic exp_active, logic [7:0] exp_pend);
        vec_t v;
        v.irq_in = irq_in; v.mask_we = mask_we; v.mask_wdata = mask_wdata;
        v.ack = ack; v.ret = ret; v.exp_req = exp_req; v.exp_cause = exp_cause;
        v.exp_active = exp_active; v.exp_pend = exp_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] irq_in, input logic ack, input logic ret);
        bus.irq_in  = irq_in;
        bus.irq_ack = ack;
        bus.irq_ret = ret;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},    32'(bus.irq_req),    32'h0);
        chk({tag, "_active"}, 32'(bus.irq_active), 32'h0);
        chk({tag, "_cause"},  32'(bus.irq_cause),  32'h0);
        chk({tag, "_vector"}, bus.irq_vector,      32'h0000_0100);
        chk({tag, "_pend"},   32'(bus.pending),    32'h0);
        chk({tag, "_count"},  bus.irq_count,       32'h0);
    endtask

    initial begin
        logic [7:0] src_bit;
        logic       seen;

        bus.irq_in = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
        bus.irq_ack = 1'b0; bus.irq_ret = 1'b0;

        //           irq_in we  wdata  ack  ret  req  cause act  pend
        // single event on source 3, then event during SERVICE on source 1
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h08));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 3'd3, 0, 8'h08));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 1, 3'd3, 0, 8'h08)); // stray ret in REQ
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 3'd3, 1, 8'h00));
        tbl.push_back(mk(8'h02, 0, 8'h00, 0, 0, 0, 3'd3, 1, 8'h02));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 3'd3, 1, 8'h02));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 3'd3, 0, 8'h02));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 3'd1, 0, 8'h02));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 3'd1, 1, 8'h00));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 3'd1, 0, 8'h00));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 3'd1, 0, 8'h00)); // stray ack in IDLE
        // priority: sources 5 and 2 together, held for a cycle
        tbl.push_back(mk(8'h24, 0, 8'h00, 0, 0, 0, 3'd1, 0, 8'h24));
        tbl.push_back(mk(8'h24, 0, 8'h00, 0, 0, 1, 3'd2, 0, 8'h24));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 3'd2, 1, 8'h20));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 3'd2, 0, 8'h20));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 3'd5, 0, 8'h20));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 1, 0, 3'd5, 1, 8'h00)); // ack+ret in REQ
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 3'd5, 0, 8'h00));
        // masking source 0
        tbl.push_back(mk(8'h00, 1, 8'hFE, 0, 0, 0, 3'd5, 0, 8'h00));
        tbl.push_back(mk(8'h01, 0, 8'h00, 0, 0, 0, 3'd5, 0, 8'h01));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 3'd5, 0, 8'h01));
        tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0, 0, 3'd5, 0, 8'h01));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 3'd0, 0, 8'h01));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 1, 0, 3'd0, 0, 8'h00)); // ack+ret in SERVICE
        // new event on the bit being acknowledged: set wins
        tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h10));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 3'd4, 0, 8'h10));
        tbl.push_back(mk(8'h10, 0, 8'h00, 1, 0, 0, 3'd4, 1, 8'h10));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 3'd4, 0, 8'h10));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 3'd4, 0, 8'h10));

        #1;
        check_reset_values("por");
        tick; tick;
        reset = 1'b0;
        tick;
        check_reset_values("post_rst");

        foreach (tbl[i]) begin
            drive(tbl[i].irq_in, tbl[i].ack, tbl[i].ret);
            bus.mask_we    = tbl[i].mask_we;
            bus.mask_wdata = tbl[i].mask_wdata;
            tick;
            chk($sformatf("v%0d_req", i),    32'(bus.irq_req),    32'(tbl[i].exp_req));
            chk($sformatf("v%0d_cause", i),  32'(bus.irq_cause),  32'(tbl[i].exp_cause));
            chk($sformatf("v%0d_vector", i), bus.irq_vector,
                32'h0000_0100 + 32'(tbl[i].exp_cause) * 32'd4);
            chk($sformatf("v%0d_active", i), 32'(bus.irq_active), 32'(tbl[i].exp_active));
            chk($sformatf("v%0d_pend", i),   32'(bus.pending),    32'(tbl[i].exp_pend));
        end
        drive(8'h00, 1'b0, 1'b0);
        bus.mask_we = 1'b0;
        chk("tbl_count", bus.irq_count, CNT_EN ? 32'd6 : 32'd0);

        // async reset while requesting cause 4: no clock edge between assert and check
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        tick;
        reset = 1'b0;
        tick;

        // counter: service three interrupts on sources 6, 5, 4
        for (int k = 0; k < 3; k++) begin
            src_bit = 8'h01 << (6 - k);
            drive(src_bit, 1'b0, 1'b0);
            tick;
            drive(8'h00, 1'b0, 1'b0);
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick;
                seen = bus.irq_req;
            end
            chk($sformatf("svc%0d_req_seen", k), 32'(seen), 32'h1);
            chk($sformatf("svc%0d_cause", k), 32'(bus.irq_cause), 32'(6 - k));
            drive(8'h00, 1'b1, 1'b0);
            tick;
            chk($sformatf("svc%0d_active", k), 32'(bus.irq_active), 32'h1);
            drive(8'h00, 1'b0, 1'b1);
            tick;
            chk($sformatf("svc%0d_idle", k), 32'(bus.irq_active), 32'h0);
            drive(8'h00, 1'b0, 1'b0);
        end
        chk("count3", bus.irq_count, CNT_EN ? 32'd3 : 32'd0);

        // held-high line yields exactly one event
        drive(8'h01, 1'b0, 1'b0);
        tick; tick;
        chk("held_req", 32'(bus.irq_req), 32'h1);
        chk("held_cause", 32'(bus.irq_cause), 32'h0);
        drive(8'h01, 1'b1, 1'b0);
        tick;
        drive(8'h01, 1'b0, 1'b1);
        tick;
        drive(8'h01, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick;
            chk($sformatf("held_noreq%0d", c), 32'(bus.irq_req), 32'h0);
            chk($sformatf("held_nopend%0d", c), 32'(bus.pending), 32'h0);
        end
        drive(8'h00, 1'b0, 1'b0);
        chk("count4", bus.irq_count, CNT_EN ? 32'd4 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
